// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the scaled VGA timing generator.
//   - 640x480@60 timing constants (pixel periods / lines)
//   - rgb888_t colour struct and the 8-entry colour-bar table
//   - timing_flags_t: per-pixel flags carried through the latency delay line
//   - block_size(): integer scale factor that fits the logical frame in the
//     active area on both axes
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // All-zero is the blanked, sync-inactive state, so an async clear of the
    // delay line flushes it to blank.
    typedef struct packed {
        logic sof;      // counter at pixel (0,0)
        logic vblank;   // line >= V_ACTIVE
        logic win;      // inside the scaled logical window
        logic active;   // inside the active display area
        logic vs;       // vertical sync asserted (polarity applied later)
        logic hs;       // horizontal sync asserted (polarity applied later)
    } timing_flags_t;

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam rgb888_t BAR_COLOURS [8] = '{
        '{8'hFF, 8'hFF, 8'hFF},
        '{8'hFF, 8'hFF, 8'h00},
        '{8'h00, 8'hFF, 8'hFF},
        '{8'h00, 8'hFF, 8'h00},
        '{8'hFF, 8'h00, 8'hFF},
        '{8'hFF, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'hFF},
        '{8'h00, 8'h00, 8'h00}
    };

    function automatic int block_size(input int h_act, input int w,
                                      input int v_act, input int h);
        int bx;
        int by;
        bx = h_act / w;
        by = v_act / h;
        return (bx < by) ? bx : by;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: WIDTH-bit, DEPTH-stage shift register advancing on i_en,
// asynchronously cleared to zero. DEPTH==0 is a combinational pass-through.
//   i_clk  clock
//   i_rst  asynchronous active-high clear
//   i_en   shift enable
//   i_d    stage input
//   o_q    output, DEPTH enabled shifts after i_d
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_thru
            assign o_q = i_d;
        end else begin : g_sr
            logic [DEPTH-1:0][WIDTH-1:0] r_sr;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_sr <= '0;
                end else if (i_en) begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scaled_timing_gen.sv
// vga_scaled_timing_gen: programmable VGA timing with a clock-enable pixel
// divider, integer-scaled centred logical x/y and pixel-source latency
// compensation.
//   CLOCK_50            system clock (only clock)
//   reset               asynchronous active-high reset
//   r, g, b             pixel colour for x/y, valid PIX_LATENCY pixels later
//   x, y                registered logical column/row
//   VGA_R/G/B           DAC colour, 0 outside the logical window
//   VGA_CLK             pixel clock, rising edge mid-pixel
//   VGA_BLANK_N         low outside the active area
//   VGA_HS, VGA_VS      syncs, active level HS_POL / VS_POL
//   VGA_SYNC_N          constant 0
//   vblank              high while the displayed line is >= V_ACTIVE
//   frame_start         one-cycle pulse when pixel (0,0) reaches the pins
// Optional build macro VGA_TEST_PATTERN_EN adds input pattern_sel, which
// replaces the colour with 8 vertical bars across the logical width.
module vga_scaled_timing_gen
    import vga_pkg::*;
#(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int CLK_DIV     = 2,
    parameter int PIX_LATENCY = 1,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       pattern_sel,
`endif
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_CLK,
    output logic       VGA_BLANK_N,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_SYNC_N,
    output logic       vblank,
    output logic       frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DW       = $clog2(CLK_DIV);
    localparam int BLOCK    = block_size(H_ACTIVE, WIDTH, V_ACTIVE, HEIGHT);
    localparam int BW       = (BLOCK > 1) ? $clog2(BLOCK) : 1;
    localparam int X_SPAN   = WIDTH * BLOCK;
    localparam int Y_SPAN   = HEIGHT * BLOCK;
    localparam int X_START  = (H_ACTIVE - X_SPAN) / 2;
    localparam int Y_START  = (V_ACTIVE - Y_SPAN) / 2;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int FL_W     = $bits(timing_flags_t);
`ifdef VGA_TEST_PATTERN_EN
    localparam int DL_W     = FL_W + 10;
`else
    localparam int DL_W     = FL_W;
`endif

    generate
        if (BLOCK == 0) begin : g_bad_block
            $error("vga_scaled_timing_gen: logical frame larger than active area");
        end
    endgenerate

    // ---------------- pixel clock-enable divider ----------------
    logic [DW-1:0] r_dcnt;
    logic [DW-1:0] w_dcnt_nxt;
    logic          w_pix_ce;
    logic          r_vga_clk;

    assign w_pix_ce   = int'(r_dcnt) == CLK_DIV - 1;
    assign w_dcnt_nxt = w_pix_ce ? '0 : r_dcnt + DW'(1);

    // Compare against the next divider value so VGA_CLK tracks r_dcnt
    // exactly while still coming straight from a flop.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_dcnt    <= '0;
            r_vga_clk <= 1'b0;
        end else begin
            r_dcnt    <= w_dcnt_nxt;
            r_vga_clk <= int'(w_dcnt_nxt) >= CLK_DIV / 2;
        end
    end

    // ---------------- h/v counters ----------------
    logic [HW-1:0] r_hcnt;
    logic [HW-1:0] w_hcnt_nxt;
    logic [VW-1:0] r_vcnt;
    logic [VW-1:0] w_vcnt_nxt;
    logic          w_hwrap;
    logic          w_vwrap;

    assign w_hwrap    = int'(r_hcnt) == H_TOTAL - 1;
    assign w_vwrap    = int'(r_vcnt) == V_TOTAL - 1;
    assign w_hcnt_nxt = w_hwrap ? '0 : r_hcnt + HW'(1);
    assign w_vcnt_nxt = !w_hwrap ? r_vcnt : (w_vwrap ? '0 : r_vcnt + VW'(1));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_pix_ce) begin
            r_hcnt <= w_hcnt_nxt;
            r_vcnt <= w_vcnt_nxt;
        end
    end

    // ---------------- logical x/y ----------------
    // x/y are loaded from the *next* counter values so that, like the
    // counters, they describe the pixel of the current pixel period.
    logic [9:0]    r_x;
    logic [8:0]    r_y;
    logic [BW-1:0] r_xsub;
    logic [BW-1:0] r_ysub;
    logic          w_hin_nxt;
    logic          w_vin_nxt;

    assign w_hin_nxt = int'(w_hcnt_nxt) >= X_START && int'(w_hcnt_nxt) < X_START + X_SPAN;
    assign w_vin_nxt = int'(w_vcnt_nxt) >= Y_START && int'(w_vcnt_nxt) < Y_START + Y_SPAN;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_x    <= '0;
            r_xsub <= '0;
        end else if (w_pix_ce) begin
            if (!w_hin_nxt || int'(w_hcnt_nxt) == X_START) begin
                r_x    <= '0;
                r_xsub <= '0;
            end else if (int'(r_xsub) == BLOCK - 1) begin
                r_xsub <= '0;
                if (int'(r_x) != WIDTH - 1) r_x <= r_x + 10'd1;
            end else begin
                r_xsub <= r_xsub + BW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_y    <= '0;
            r_ysub <= '0;
        end else if (w_pix_ce && w_hwrap) begin
            if (!w_vin_nxt || int'(w_vcnt_nxt) == Y_START) begin
                r_y    <= '0;
                r_ysub <= '0;
            end else if (int'(r_ysub) == BLOCK - 1) begin
                r_ysub <= '0;
                if (int'(r_y) != HEIGHT - 1) r_y <= r_y + 9'd1;
            end else begin
                r_ysub <= r_ysub + BW'(1);
            end
        end
    end

    // ---------------- counter-stage flags and latency delay ----------------
    timing_flags_t w_flags;
    timing_flags_t w_d_flags;
    logic [DL_W-1:0] w_dl_in;
    logic [DL_W-1:0] w_dl_out;

    always_comb begin
        w_flags        = '0;
        w_flags.hs     = int'(r_hcnt) >= HS_START && int'(r_hcnt) < HS_START + H_SYNC;
        w_flags.vs     = int'(r_vcnt) >= VS_START && int'(r_vcnt) < VS_START + V_SYNC;
        w_flags.active = int'(r_hcnt) < H_ACTIVE && int'(r_vcnt) < V_ACTIVE;
        w_flags.win    = int'(r_hcnt) >= X_START && int'(r_hcnt) < X_START + X_SPAN &&
                         int'(r_vcnt) >= Y_START && int'(r_vcnt) < Y_START + Y_SPAN;
        w_flags.vblank = int'(r_vcnt) >= V_ACTIVE;
        w_flags.sof    = r_hcnt == '0 && r_vcnt == '0;
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [9:0] w_d_x;
    logic [2:0] w_bar;

    assign w_dl_in = {r_x, w_flags};
    assign {w_d_x, w_d_flags} = w_dl_out;
    assign w_bar = 3'((int'(w_d_x) * 8) / WIDTH);
`else
    assign w_dl_in   = w_flags;
    assign w_d_flags = w_dl_out;
`endif

    vga_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (PIX_LATENCY)
    ) u_delay (
        .i_clk (CLOCK_50),
        .i_rst (reset),
        .i_en  (w_pix_ce),
        .i_d   (w_dl_in),
        .o_q   (w_dl_out)
    );

    // ---------------- output stage ----------------
    rgb888_t w_rgb;
    rgb888_t r_rgb;
    logic    r_blank_n;
    logic    r_hs;
    logic    r_vs;
    logic    r_vblank;
    logic    r_frame_start;

    always_comb begin
        w_rgb = '{r: r, g: g, b: b};
`ifdef VGA_TEST_PATTERN_EN
        if (pattern_sel) w_rgb = BAR_COLOURS[w_bar];
`endif
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_rgb     <= '0;
            r_blank_n <= 1'b0;
            r_hs      <= ~HS_POL;
            r_vs      <= ~VS_POL;
            r_vblank  <= 1'b0;
        end else if (w_pix_ce) begin
            r_rgb     <= (w_d_flags.win && w_d_flags.active) ? w_rgb : '0;
            r_blank_n <= w_d_flags.active;
            r_hs      <= w_d_flags.hs ? HS_POL : ~HS_POL;
            r_vs      <= w_d_flags.vs ? VS_POL : ~VS_POL;
            r_vblank  <= w_d_flags.vblank;
        end
    end

    // Pulse lasts exactly one CLOCK_50 cycle after the edge that puts (0,0)
    // on the pins.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_frame_start <= 1'b0;
        else       r_frame_start <= w_pix_ce && w_d_flags.sof;
    end

    assign x           = r_x;
    assign y           = r_y;
    assign VGA_R       = r_rgb.r;
    assign VGA_G       = r_rgb.g;
    assign VGA_B       = r_rgb.b;
    assign VGA_CLK     = r_vga_clk;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_SYNC_N  = 1'b0;
    assign vblank      = r_vblank;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scaled_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_scaled_timing_gen;

    // Small timing so whole frames fit in the run.
    localparam int WIDTH = 20, HEIGHT = 10;
    localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
    localparam int VA = 24, VFP = 2, VSY = 2, VBP = 2;
    localparam int CD = 4, PL = 3;
    localparam bit HSP = 1'b0, VSP = 1'b1;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FT  = HT * VT;
    localparam int BLK = (HA / WIDTH < VA / HEIGHT) ? HA / WIDTH : VA / HEIGHT;
    localparam int XS  = (HA - WIDTH * BLK) / 2;
    localparam int YS  = (VA - HEIGHT * BLK) / 2;

    logic       gclk = 1'b0;
    logic       rst  = 1'b0;
    logic [7:0] r = '0, g = '0, b = '0;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] vr, vg, vb;
    logic       vclk, blank_n, hs, vs, sync_n, vblank, fs;
`ifdef VGA_TEST_PATTERN_EN
    logic       pattern_sel = 1'b0;
`endif

    vga_scaled_timing_gen #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .CLK_DIV(CD), .PIX_LATENCY(PL), .HS_POL(HSP), .VS_POL(VSP)
    ) dut (
        .CLOCK_50(gclk), .reset(rst), .r(r), .g(g), .b(b),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .x(x), .y(y), .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .VGA_CLK(vclk),
        .VGA_BLANK_N(blank_n), .VGA_HS(hs), .VGA_VS(vs), .VGA_SYNC_N(sync_n),
        .vblank(vblank), .frame_start(fs)
    );

    always #5 gclk = ~gclk;

    int         errors = 0, checks = 0;
    logic [7:0] r_samp = '0;   // r value present at the last pix_ce edge
    int         hx[$], hy[$];  // DUT x/y seen per pixel period (pixel source)

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: scaled window geometry from plain arithmetic.
    function automatic bit inx(input int h); return h >= XS && h < XS + WIDTH * BLK; endfunction
    function automatic bit iny(input int v); return v >= YS && v < YS + HEIGHT * BLK; endfunction
    function automatic int colf(input int h); return inx(h) ? (h - XS) / BLK : 0; endfunction
    function automatic int rowf(input int v); return iny(v) ? (v - YS) / BLK : 0; endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_x"}, 32'(x), 0);
        chk({tag, "_y"}, 32'(y), 0);
        chk({tag, "_rgb"}, 32'({vr, vg, vb}), 0);
        chk({tag, "_blank_n"}, 32'(blank_n), 0);
        chk({tag, "_vga_clk"}, 32'(vclk), 0);
        chk({tag, "_hs"}, 32'(hs), 32'(!HSP));
        chk({tag, "_vs"}, 32'(vs), 32'(!VSP));
        chk({tag, "_vblank"}, 32'(vblank), 0);
        chk({tag, "_frame_start"}, 32'(fs), 0);
        chk({tag, "_sync_n"}, 32'(sync_n), 0);
    endtask

    // State after e clock edges since reset release.
    task automatic check_state(input int e);
        int  p, q, h, v;
        bit  show;
        p = e / CD;          // pixel period at the counters / x,y
        q = p - 1 - PL;      // pixel currently on the pins
        chk("vga_clk", 32'(vclk), 32'((e % CD) >= CD / 2));
        chk("x", 32'(x), colf(p % HT));
        chk("y", 32'(y), rowf((p / HT) % VT));
        chk("sync_n", 32'(sync_n), 0);
        if (q < 0) begin
            chk("hs_flush", 32'(hs), 32'(!HSP));
            chk("vs_flush", 32'(vs), 32'(!VSP));
            chk("blank_n_flush", 32'(blank_n), 0);
            chk("vblank_flush", 32'(vblank), 0);
            chk("rgb_flush", 32'({vr, vg, vb}), 0);
        end else begin
            h = q % HT;
            v = (q / HT) % VT;
            show = inx(h) && iny(v);
            chk("hs", 32'(hs), 32'((h >= HA + HFP && h < HA + HFP + HSY) ? HSP : !HSP));
            chk("vs", 32'(vs), 32'((v >= VA + VFP && v < VA + VFP + VSY) ? VSP : !VSP));
            chk("blank_n", 32'(blank_n), 32'(h < HA && v < VA));
            chk("vblank", 32'(vblank), 32'(v >= VA));
            chk("vga_r", 32'(vr), show ? 32'(r_samp) : 0);
            chk("vga_g", 32'(vg), show ? colf(h) % 256 : 0);
            chk("vga_b", 32'(vb), show ? rowf(v) % 256 : 0);
        end
        chk("frame_start", 32'(fs), 32'(e % CD == 0 && q >= 0 && q % FT == 0));
    endtask

    // Inputs for the edge following state e. Between pix_ce edges everything
    // is random noise; at a pix_ce edge g/b come from a PL-deep pixel source
    // fed by x/y and r stays random (recorded for the expectation).
    task automatic drive(input int e);
        int p;
        p = e / CD;
        r = 8'($urandom);
        if ((e + 1) % CD == 0) begin
            r_samp = r;
            g = (p >= PL) ? 8'(hx[p - PL]) : 8'($urandom);
            b = (p >= PL) ? 8'(hy[p - PL]) : 8'($urandom);
        end else begin
            g = 8'($urandom);
            b = 8'($urandom);
        end
    endtask

    // Release reset at a negedge and run ncyc checked cycles.
    task automatic run(input int ncyc);
        hx.delete();
        hy.delete();
        rst = 1'b0;
        for (int e = 0; e < ncyc; e++) begin
            check_state(e);
            if (e % CD == 0) begin
                hx.push_back(int'(x));
                hy.push_back(int'(y));
            end
            drive(e);
            @(negedge gclk);
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(negedge gclk);
        check_reset("por");

        // Through one full frame into the next, stopping mid-line inside the
        // window with VGA_CLK high.
        run((FT + 5 * HT + 30) * CD + 2);

        // Asynchronous reset between edges: pins must react before next edge.
        rst = 1'b1;
        #1;
        check_reset("async");
        repeat (3) begin
            @(negedge gclk);
            r = 8'($urandom);
            check_reset("hold");
        end

        // Restart: flushed pipeline, frame_start once after (PL+1)*CD cycles,
        // then one more full frame.
        run(FT * CD + 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
